// File: rtl/alu_operand_fetch_if.sv
// Purpose: operand-staging bus between the word producer and the operand mux.
// Latency: none; this file only groups wires.
// Backpressure: in_valid/in_ready on the word side, out_valid/out_ready on the pair side.
interface alu_operand_fetch_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    // Upstream word side
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    // Downstream pair side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             select;
    logic [CNT_W-1:0] pair_cnt;

    // Producer/consumer view: drives words and accepts pairs
    modport master (
        output flush, in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, op_a, op_b, select, pair_cnt
    );

    // Staging stage view
    modport slave (
        input  flush, in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, op_a, op_b, select, pair_cnt
    );
endinterface

// File: rtl/alu_operand_fetch.sv
// Purpose: collects operand A (with select) then operand B from one shared bus and presents them as a pair.
// Latency: out_valid rises one cycle after the B transfer edge; minimum 3 cycles per pair.
// Backpressure: in_ready drops while a pair is held; the pair stays stable until out_ready accepts it.
module alu_operand_fetch #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_operand_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q,  op_a_d;
    logic [WIDTH-1:0]   op_b_q,  op_b_d;
    logic               sel_q,   sel_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // Handshake flags are pure state decodes so no input reaches an output combinationally.
    logic               in_ready_w;
    logic               out_valid_w;

    // Moore decode of the two handshake outputs
    always_comb begin
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        case (state_q)
            LOAD_A:  in_ready_w  = 1'b1;
            LOAD_B:  in_ready_w  = 1'b1;
            HOLD:    out_valid_w = 1'b1;
            default: in_ready_w  = 1'b0;
        endcase
    end

    // Next-state and datapath capture; flush outranks a word offered in the same cycle
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD_A: begin
                // Nothing is partially loaded here, so flush only suppresses the transfer.
                if (bus.in_valid && !bus.flush) begin
                    op_a_d  = bus.in_data;
                    sel_d   = bus.in_sel;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                // A stale op_a/select survive a flush but are never presented without a fresh A.
                if (bus.flush) begin
                    state_d = LOAD_A;
                end else if (bus.in_valid) begin
                    op_b_d  = bus.in_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Flush is ignored so a completed pair is never dropped; exit takes a full cycle.
                if (bus.out_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.select    = sel_q;
    assign bus.pair_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Purpose: self-checking bench for alu_operand_fetch using a pair scoreboard.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: exercised by holding out_ready low while a pair is presented.
module tb_alu_operand_fetch;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sel;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt  = 0;
    int   check_cnt = 0;
    logic [CNT_W-1:0] m_cnt;
    exp_t sb[$];

    alu_operand_fetch_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_operand_fetch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle: the rising edge consumes inputs, return at the falling edge to sample.
    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_word(input logic [WIDTH-1:0] d, input logic s);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        m_cnt = '0;
        check_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
        check_cnt++; if (bus.in_ready !== 1'b1)  $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
        check_cnt++; if (bus.op_a !== 16'h0)     $display("FAIL reset_op_a got=%h exp=0000", bus.op_a); else pass_cnt++;
        check_cnt++; if (bus.op_b !== 16'h0)     $display("FAIL reset_op_b got=%h exp=0000", bus.op_b); else pass_cnt++;
        check_cnt++; if (bus.select !== 1'b0)    $display("FAIL reset_select got=%b exp=0", bus.select); else pass_cnt++;
        check_cnt++; if (bus.pair_cnt !== 8'd0)  $display("FAIL reset_pair_cnt got=%0d exp=0", bus.pair_cnt); else pass_cnt++;
    endtask

    // Basic pair, including in_sel flipped during the B word
    task automatic test_basic_pair();
        exp_t e;
        drive_word(16'h1234, 1'b1);
        cycle();
        check_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL basic_after_a got vld=%b rdy=%b exp vld=0 rdy=1", bus.out_valid, bus.in_ready); else pass_cnt++;
        drive_word(16'hABCD, 1'b0);
        sb.push_back('{a: 16'h1234, b: 16'hABCD, sel: 1'b1, cnt: m_cnt});
        cycle();
        bus.in_valid = 1'b0;
        check_cnt++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            $display("FAIL basic_latency got vld=%b rdy=%b exp vld=1 rdy=0", bus.out_valid, bus.in_ready); else pass_cnt++;
        e = sb.pop_front();
        check_cnt++; if (bus.op_a !== e.a)       $display("FAIL basic_op_a got=%h exp=%h", bus.op_a, e.a); else pass_cnt++;
        check_cnt++; if (bus.op_b !== e.b)       $display("FAIL basic_op_b got=%h exp=%h", bus.op_b, e.b); else pass_cnt++;
        check_cnt++; if (bus.select !== e.sel)   $display("FAIL basic_select_b_toggle got=%b exp=%b", bus.select, e.sel); else pass_cnt++;
        check_cnt++; if (bus.pair_cnt !== e.cnt) $display("FAIL basic_cnt_before got=%0d exp=%0d", bus.pair_cnt, e.cnt); else pass_cnt++;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        m_cnt = m_cnt + 8'd1;
        check_cnt++; if (bus.pair_cnt !== m_cnt) $display("FAIL basic_cnt_after got=%0d exp=%0d", bus.pair_cnt, m_cnt); else pass_cnt++;
        check_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL basic_back_to_load_a got vld=%b rdy=%b exp vld=0 rdy=1", bus.out_valid, bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        drive_word(16'h0A0A, 1'b0);
        cycle();
        drive_word(16'h0B0B, 1'b1);
        sb.push_back('{a: 16'h0A0A, b: 16'h0B0B, sel: 1'b0, cnt: m_cnt});
        cycle();
        e = sb.pop_front();
        drive_word(16'hFFFF, 1'b1);
        bus.flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_cnt++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.op_a !== e.a ||
                bus.op_b !== e.b || bus.select !== e.sel || bus.pair_cnt !== e.cnt)
                $display("FAIL bp_hold%0d got rdy=%b vld=%b a=%h b=%h s=%b c=%0d exp rdy=0 vld=1 a=%h b=%h s=%b c=%0d",
                         i, bus.in_ready, bus.out_valid, bus.op_a, bus.op_b, bus.select, bus.pair_cnt,
                         e.a, e.b, e.sel, e.cnt);
            else pass_cnt++;
            cycle();
        end
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        m_cnt = m_cnt + 8'd1;
        check_cnt++; if (bus.pair_cnt !== m_cnt) $display("FAIL bp_cnt got=%0d exp=%0d", bus.pair_cnt, m_cnt); else pass_cnt++;
        check_cnt++; if (bus.op_a !== e.a || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_no_capture_on_handoff got a=%h vld=%b rdy=%b exp a=%h vld=0 rdy=1",
                     bus.op_a, bus.out_valid, bus.in_ready, e.a); else pass_cnt++;
    endtask

    task automatic test_flush();
        exp_t e;
        drive_word(16'h0001, 1'b1);
        cycle();
        drive_word(16'h0002, 1'b1);
        bus.flush = 1'b1;
        cycle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pair_cnt !== m_cnt)
            $display("FAIL flush_state got vld=%b rdy=%b c=%0d exp vld=0 rdy=1 c=%0d",
                     bus.out_valid, bus.in_ready, bus.pair_cnt, m_cnt); else pass_cnt++;
        drive_word(16'h0003, 1'b0);
        cycle();
        check_cnt++; if (bus.out_valid !== 1'b0)
            $display("FAIL flush_back_in_load_a got vld=%b exp=0", bus.out_valid); else pass_cnt++;
        drive_word(16'h0004, 1'b1);
        sb.push_back('{a: 16'h0003, b: 16'h0004, sel: 1'b0, cnt: m_cnt});
        cycle();
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        check_cnt++;
        if (bus.out_valid !== 1'b1 || bus.op_a !== e.a || bus.op_b !== e.b || bus.select !== e.sel)
            $display("FAIL flush_next_pair got vld=%b a=%h b=%h s=%b exp vld=1 a=%h b=%h s=%b",
                     bus.out_valid, bus.op_a, bus.op_b, bus.select, e.a, e.b, e.sel);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        m_cnt = m_cnt + 8'd1;
        check_cnt++; if (bus.pair_cnt !== m_cnt) $display("FAIL flush_cnt got=%0d exp=%0d", bus.pair_cnt, m_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_hold();
        drive_word(16'h5555, 1'b1);
        cycle();
        drive_word(16'h6666, 1'b0);
        cycle();
        bus.in_valid = 1'b0;
        check_cnt++; if (bus.out_valid !== 1'b1 || bus.op_a !== 16'h5555)
            $display("FAIL rst_hold_pre got vld=%b a=%h exp vld=1 a=5555", bus.out_valid, bus.op_a); else pass_cnt++;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        m_cnt = '0;
        check_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.op_a !== 16'h0 ||
            bus.op_b !== 16'h0 || bus.select !== 1'b0 || bus.pair_cnt !== 8'd0)
            $display("FAIL rst_hold_post got vld=%b rdy=%b a=%h b=%h s=%b c=%0d exp vld=0 rdy=1 a=0000 b=0000 s=0 c=0",
                     bus.out_valid, bus.in_ready, bus.op_a, bus.op_b, bus.select, bus.pair_cnt);
        else pass_cnt++;
    endtask

    // 256 pairs at full rate with in_valid and out_ready held high; count wraps to zero
    task automatic test_back_to_back();
        exp_t e;
        logic [WIDTH-1:0] a, b;
        logic s;
        int   errs = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            s = 1'($urandom);
            drive_word(a, s);
            cycle();
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) errs++;
            drive_word(b, ~s);
            sb.push_back('{a: a, b: b, sel: s, cnt: m_cnt});
            cycle();
            drive_word(16'hDEAD, ~s);
            e = sb.pop_front();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.op_a !== e.a ||
                bus.op_b !== e.b || bus.select !== e.sel || bus.pair_cnt !== e.cnt) begin
                if (errs < 3)
                    $display("FAIL b2b_pair%0d got vld=%b a=%h b=%h s=%b c=%0d exp vld=1 a=%h b=%h s=%b c=%0d",
                             i, bus.out_valid, bus.op_a, bus.op_b, bus.select, bus.pair_cnt,
                             e.a, e.b, e.sel, e.cnt);
                errs++;
            end
            cycle();
            m_cnt = m_cnt + 8'd1;
        end
        drive_idle();
        check_cnt++; if (errs != 0) $display("FAIL b2b_stream got errors=%0d exp=0", errs); else pass_cnt++;
        check_cnt++; if (bus.pair_cnt !== 8'd0) $display("FAIL b2b_wrap got=%0d exp=0", bus.pair_cnt); else pass_cnt++;
        check_cnt++; if (sb.size() != 0) $display("FAIL b2b_scoreboard got=%0d exp=0", sb.size()); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        m_cnt = '0;
        drive_idle();
        cycle();
        test_reset();
        test_basic_pair();
        test_backpressure();
        test_flush();
        test_reset_mid_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("%0d/%0d checks passed", pass_cnt, check_cnt + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
- Upstream operand-staging stage for the 16-bit 2:1 operand mux (select=1 passes A, select=0 passes B).
- Collects two operand words, A then B, from a single shared 16-bit input bus using a valid/ready handshake.
- Holds A, B and the captured select stable, with out_valid, until the consumer accepts them.
- Counts completed operand pairs.

Parameters:
- WIDTH, 16, operand width in bits; must match the mux width.
- CNT_W, 8, width of the pair counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous abort of a partially loaded pair.
- in_valid  in  1  in_data/in_sel are valid this cycle.
- in_ready  out  1  stage can accept a word this cycle.
- in_data  in  WIDTH  operand word: first word is A, second is B.
- in_sel  in  1  mux select for the pair; sampled only with the A word.
- out_valid  out  1  A, B and select form a complete pair.
- out_ready  in  1  consumer accepts the pair this cycle.
- op_a  out  WIDTH  registered operand A, to mux input A.
- op_b  out  WIDTH  registered operand B, to mux input B.
- select  out  1  registered select, to mux select.
- pair_cnt  out  CNT_W  number of accepted pairs, modulo 2^CNT_W.

Behaviour:
- Reset is synchronous on rising clk with rst_n=0. It has priority over everything, including mid-pair or mid-hold.
- Reset values: state=LOAD_A, op_a=0, op_b=0, select=0, pair_cnt=0, out_valid=0, in_ready=1.
- A transfer occurs when in_valid=1 and in_ready=1 at a rising edge.
- FSM states: LOAD_A, LOAD_B, HOLD.
- LOAD_A: in_ready=1, out_valid=0. On transfer, op_a<=in_data, select<=in_sel, next state LOAD_B.
- LOAD_B: in_ready=1, out_valid=0. On transfer, op_b<=in_data, next state HOLD. in_sel is ignored in this state.
- HOLD: in_ready=0, out_valid=1. op_a, op_b and select are held stable.
- HOLD with out_ready=1: pair_cnt<=pair_cnt+1 (wraps from 2^CNT_W-1 to 0), next state LOAD_A.
- HOLD exit is one cycle only: no acceptance of a new A in the same cycle as the pair handoff. Throughput is 3 cycles per pair minimum.
- in_ready and out_valid are decoded purely from state (Moore). No combinational path from any input to any output.
- Latency: out_valid rises one cycle after the B transfer edge.
- flush=1 in LOAD_B: next state LOAD_A. op_a and select keep their values but are not presented; pair_cnt is unchanged. A word offered in the same cycle is not accepted, since flush has priority over the transfer.
- flush=1 in LOAD_A: no effect; no transfer occurs that cycle.
- flush=1 in HOLD: ignored, so a completed pair is never dropped.
- in_valid=0: state is held. Idle cycles between the A and B words are allowed.
- out_ready=1 outside HOLD: no effect.
- Registers update only on transfers. op_b retains the previous B until a new B transfer.

Test Plan:
- Reset, then A=0x1234 with in_sel=1, then B=0xABCD, out_ready=1 -> out_valid high exactly one cycle after the B edge. op_a=0x1234, op_b=0xABCD, select=1, pair_cnt goes 0->1 on handoff, then state returns to LOAD_A.
- Backpressure: complete a pair, hold out_ready=0 for 5 cycles with in_valid=1 and in_data=0xFFFF -> in_ready=0, outputs stay stable, no capture. Raising out_ready hands off and increments the count.
- Flush: A=0x0001, then flush=1 with in_valid=1 and in_data=0x0002 -> no transfer, state LOAD_A, pair_cnt unchanged. Next pair A=0x0003/B=0x0004 with in_sel=0 presents select=0.
- Reset mid-HOLD with op_a=0x5555 -> next cycle all outputs at reset values, out_valid=0, in_ready=1.
- Wrap: 256 back-to-back pairs with CNT_W=8 -> pair_cnt returns to 0. Throughput is one pair per 3 cycles with in_valid and out_ready held at 1.
- in_sel toggled during the B word (in_sel=0 after A with in_sel=1) -> select stays 1.
